// File: rtl/lsq_mem_arbiter_if.sv
// Bundle between the LS unit / store queue / memory bus and the arbiter.
// The master modport is the arbiter side; slave is the environment side.
interface lsq_mem_arbiter_if #(
  parameter int XLEN        = 32,
  parameter int LSQ_IDX_LEN = 4
);
  logic                   ld_req_valid;
  logic [XLEN-1:0]        ld_req_addr;
  logic [2:0]             ld_req_funct3;
  logic [LSQ_IDX_LEN-1:0] ld_req_tag;
  logic                   ld_req_ready;

  logic                   st_req_valid;
  logic [XLEN-1:0]        st_req_addr;
  logic [XLEN-1:0]        st_req_data;
  logic [1:0]             st_req_size;
  logic                   st_req_ready;
  logic                   st_done;

  logic                   ld_resp_valid;
  logic [LSQ_IDX_LEN-1:0] ld_resp_tag;
  logic [XLEN-1:0]        ld_resp_value;

  logic [1:0]             proc2mem_command;
  logic [XLEN-1:0]        proc2mem_addr;
  logic [63:0]            proc2mem_data;
  logic [1:0]             proc2mem_size;
  logic [3:0]             mem2proc_response;
  logic [63:0]            mem2proc_data;
  logic [3:0]             mem2proc_tag;

  logic                   busy;

  modport master (
    input  ld_req_valid, ld_req_addr, ld_req_funct3, ld_req_tag,
    input  st_req_valid, st_req_addr, st_req_data, st_req_size,
    input  mem2proc_response, mem2proc_data, mem2proc_tag,
    output ld_req_ready, st_req_ready, st_done,
    output ld_resp_valid, ld_resp_tag, ld_resp_value,
    output proc2mem_command, proc2mem_addr, proc2mem_data, proc2mem_size,
    output busy
  );

  modport slave (
    output ld_req_valid, ld_req_addr, ld_req_funct3, ld_req_tag,
    output st_req_valid, st_req_addr, st_req_data, st_req_size,
    output mem2proc_response, mem2proc_data, mem2proc_tag,
    input  ld_req_ready, st_req_ready, st_done,
    input  ld_resp_valid, ld_resp_tag, ld_resp_value,
    input  proc2mem_command, proc2mem_addr, proc2mem_data, proc2mem_size,
    input  busy
  );
endinterface

// File: rtl/lsq_mem_arbiter.sv
// Single-port memory sequencer: arbitrates LS-unit loads against retiring
// stores, drives the tagged memory protocol and returns extended load data.
module lsq_mem_arbiter #(
  parameter int XLEN         = 32,
  parameter int LSQ_IDX_LEN  = 4,
  parameter int STARVE_LIMIT = 4
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               squash,
  lsq_mem_arbiter_if.master  bus
);
  localparam int CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [1:0] BUS_NONE = 2'd0, BUS_LOAD = 2'd1, BUS_STORE = 2'd2;

  typedef enum logic [1:0] {IDLE, REQ_LD, REQ_ST, WAIT_DATA} state_e;

  typedef struct packed {
    logic [XLEN-1:0]        addr;
    logic [XLEN-1:0]        data;
    logic [1:0]             size;
    logic                   uns;
    logic [LSQ_IDX_LEN-1:0] tag;
  } req_t;

  state_e                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  req_t                   req_q, req_d;
  logic [3:0]             mtag_q, mtag_d;
  logic                   discard_q, discard_d;
  logic                   st_done_q, st_done_d;
  logic                   resp_valid_q, resp_valid_d;
  logic [LSQ_IDX_LEN-1:0] resp_tag_q, resp_tag_d;
  logic [XLEN-1:0]        resp_value_q, resp_value_d;

  logic starve, ld_ready, st_ready, ld_go, st_go, rsp_ok, tag_hit;
  logic [1:0]      cmd, size_o;
  logic [XLEN-1:0] addr_o;
  logic [63:0]     data_o;
  logic [31:0]     word, sh;
  logic [XLEN-1:0] ext;

  assign starve  = (cnt_q == CW'(STARVE_LIMIT));
  assign rsp_ok  = |bus.mem2proc_response;
  assign tag_hit = (mtag_q != 4'd0) && (bus.mem2proc_tag == mtag_q);
  assign ld_go   = ld_ready && bus.ld_req_valid;
  assign st_go   = st_ready && bus.st_req_valid;

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      req_q        <= '0;
      mtag_q       <= '0;
      discard_q    <= 1'b0;
      st_done_q    <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_tag_q   <= '0;
      resp_value_q <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      req_q        <= req_d;
      mtag_q       <= mtag_d;
      discard_q    <= discard_d;
      st_done_q    <= st_done_d;
      resp_valid_q <= resp_valid_d;
      resp_tag_q   <= resp_tag_d;
      resp_value_q <= resp_value_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:      if (ld_go) state_d = REQ_LD; else if (st_go) state_d = REQ_ST;
      REQ_LD:    if (rsp_ok) state_d = WAIT_DATA; else if (squash) state_d = IDLE;
      REQ_ST:    if (rsp_ok) state_d = IDLE;
      WAIT_DATA: if (tag_hit) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  // Readys are gated by reset so nothing is accepted during the reset cycle.
  always_comb begin
    ld_ready = reset && (state_q == IDLE) && !squash && !(bus.st_req_valid && starve);
    st_ready = reset && (state_q == IDLE) && (!bus.ld_req_valid || squash || starve);
    cmd      = BUS_NONE;
    addr_o   = '0;
    data_o   = '0;
    size_o   = '0;
    if (state_q == REQ_LD) begin
      cmd    = BUS_LOAD;
      addr_o = req_q.addr;
      size_o = req_q.size;
    end else if (state_q == REQ_ST) begin
      cmd    = BUS_STORE;
      addr_o = req_q.addr;
      data_o = 64'(req_q.data);
      size_o = req_q.size;
    end
  end

  always_comb begin
    word = req_q.addr[2] ? bus.mem2proc_data[63:32] : bus.mem2proc_data[31:0];
    sh   = word >> {req_q.addr[1:0], 3'b000};
    case (req_q.size)
      2'd0:    ext = req_q.uns ? {24'b0, sh[7:0]}  : {{24{sh[7]}}, sh[7:0]};
      2'd1:    ext = req_q.uns ? {16'b0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
      default: ext = sh;
    endcase
  end

  always_comb begin
    cnt_d = cnt_q;
    if (st_go) cnt_d = '0;
    else if (ld_go && bus.st_req_valid && !starve) cnt_d = cnt_q + CW'(1);

    req_d = req_q;
    if (ld_go) begin
      req_d.addr = bus.ld_req_addr;
      req_d.size = bus.ld_req_funct3[1:0];
      req_d.uns  = bus.ld_req_funct3[2];
      req_d.tag  = bus.ld_req_tag;
    end else if (st_go) begin
      req_d.addr = bus.st_req_addr;
      req_d.data = bus.st_req_data;
      req_d.size = bus.st_req_size;
      req_d.uns  = 1'b0;
    end

    mtag_d    = mtag_q;
    discard_d = discard_q;
    if (state_q == REQ_LD && rsp_ok) begin
      mtag_d = bus.mem2proc_response;
      if (squash) discard_d = 1'b1;
    end
    // A squashed load still owns the bus tag; drop its data when it returns.
    if (state_q == WAIT_DATA) begin
      if (tag_hit) discard_d = 1'b0;
      else if (squash) discard_d = 1'b1;
    end

    st_done_d    = (state_q == REQ_ST) && rsp_ok;
    resp_valid_d = (state_q == WAIT_DATA) && tag_hit && !discard_q && !squash;
    resp_tag_d   = resp_valid_d ? req_q.tag : resp_tag_q;
    resp_value_d = resp_valid_d ? ext : resp_value_q;
  end

  assign bus.ld_req_ready     = ld_ready;
  assign bus.st_req_ready     = st_ready;
  assign bus.st_done          = st_done_q;
  assign bus.ld_resp_valid    = resp_valid_q;
  assign bus.ld_resp_tag      = resp_tag_q;
  assign bus.ld_resp_value    = resp_value_q;
  assign bus.proc2mem_command = cmd;
  assign bus.proc2mem_addr    = addr_o;
  assign bus.proc2mem_data    = data_o;
  assign bus.proc2mem_size    = size_o;
  assign bus.busy             = (state_q != IDLE);
endmodule

// File: tb/tb_lsq_mem_arbiter.sv
// Directed bench for lsq_mem_arbiter with a hand-driven memory bus.
module tb_lsq_mem_arbiter;
  localparam int XLEN = 32, TW = 4;

  logic clk = 1'b0;
  logic rst;
  logic squash;
  int   tests = 0;
  int   fails = 0;
  logic is_ld;
  string pat;

  lsq_mem_arbiter_if #(.XLEN(XLEN), .LSQ_IDX_LEN(TW)) bus();

  lsq_mem_arbiter #(.XLEN(XLEN), .LSQ_IDX_LEN(TW), .STARVE_LIMIT(4)) dut (
    .clock (clk),
    .reset (rst),
    .squash(squash),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", name, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  task automatic clear_inputs;
    squash                = 1'b0;
    bus.ld_req_valid      = 1'b0;
    bus.ld_req_addr       = '0;
    bus.ld_req_funct3     = '0;
    bus.ld_req_tag        = '0;
    bus.st_req_valid      = 1'b0;
    bus.st_req_addr       = '0;
    bus.st_req_data       = '0;
    bus.st_req_size       = '0;
    bus.mem2proc_response = '0;
    bus.mem2proc_data     = '0;
    bus.mem2proc_tag      = '0;
  endtask

  // Load with bus response in the first REQ_LD cycle and data tag right after.
  task automatic do_load(input string nm, input logic [31:0] a, input logic [2:0] f3,
                         input logic [3:0] t, input logic [63:0] d, input logic [31:0] exp);
    bus.ld_req_valid = 1'b1; bus.ld_req_addr = a; bus.ld_req_funct3 = f3; bus.ld_req_tag = t;
    #1;
    chk({nm, " ready"}, bus.ld_req_ready, 1);
    tick;
    bus.ld_req_valid = 1'b0; bus.mem2proc_response = 4'd6;
    #1;
    chk({nm, " cmd"}, bus.proc2mem_command, 1);
    tick;
    bus.mem2proc_response = 4'd0; bus.mem2proc_tag = 4'd6; bus.mem2proc_data = d;
    #1;
    chk({nm, " early"}, bus.ld_resp_valid, 0);
    tick;
    bus.mem2proc_tag = 4'd0;
    #1;
    chk({nm, " valid"}, bus.ld_resp_valid, 1);
    chk({nm, " value"}, bus.ld_resp_value, exp);
    chk({nm, " tag"}, bus.ld_resp_tag, t);
    tick;
    #1;
    chk({nm, " pulse"}, bus.ld_resp_valid, 0);
  endtask

  initial begin
    clear_inputs();
    rst = 1'b0;
    bus.ld_req_valid = 1'b1;
    tick; tick;
    #1;
    chk("rst ld_ready", bus.ld_req_ready, 0);
    chk("rst cmd", bus.proc2mem_command, 0);
    chk("rst busy", bus.busy, 0);
    chk("rst st_done", bus.st_done, 0);
    chk("rst resp_valid", bus.ld_resp_valid, 0);
    bus.ld_req_valid = 1'b0;
    rst = 1'b1;
    tick;

    // LW, data tag two cycles after the accept-response
    bus.ld_req_valid = 1'b1; bus.ld_req_addr = 32'h1004; bus.ld_req_funct3 = 3'b010; bus.ld_req_tag = 4'd5;
    #1;
    chk("lw ready", bus.ld_req_ready, 1);
    tick;
    bus.ld_req_valid = 1'b0; bus.mem2proc_response = 4'd3;
    #1;
    chk("lw cmd", bus.proc2mem_command, 1);
    chk("lw addr", bus.proc2mem_addr, 32'h1004);
    chk("lw size", bus.proc2mem_size, 2);
    chk("lw busy", bus.busy, 1);
    tick;
    bus.mem2proc_response = 4'd0;
    #1;
    chk("lw wait cmd", bus.proc2mem_command, 0);
    chk("lw wait valid", bus.ld_resp_valid, 0);
    tick;
    bus.mem2proc_tag = 4'd3; bus.mem2proc_data = 64'hAAAA_BBBB_1111_2222;
    tick;
    bus.mem2proc_tag = 4'd0;
    #1;
    chk("lw valid", bus.ld_resp_valid, 1);
    chk("lw value", bus.ld_resp_value, 32'hAAAABBBB);
    chk("lw tag", bus.ld_resp_tag, 5);
    chk("lw idle", bus.busy, 0);
    tick;
    #1;
    chk("lw pulse", bus.ld_resp_valid, 0);

    do_load("lb",  32'h1001, 3'b000, 4'd1, 64'h0000_0000_0000_8000, 32'hFFFFFF80);
    do_load("lbu", 32'h1001, 3'b100, 4'd2, 64'h0000_0000_0000_8000, 32'h00000080);
    do_load("lh",  32'h1002, 3'b001, 4'd7, 64'h0000_0000_8001_0000, 32'hFFFF8001);

    // Store rejected twice, then accepted with response 5
    bus.st_req_valid = 1'b1; bus.st_req_addr = 32'h2000; bus.st_req_data = 32'hDEADBEEF; bus.st_req_size = 2'd2;
    #1;
    chk("st ready", bus.st_req_ready, 1);
    tick;
    bus.st_req_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.mem2proc_response = (i == 2) ? 4'd5 : 4'd0;
      #1;
      chk($sformatf("st cmd%0d", i), bus.proc2mem_command, 2);
      chk($sformatf("st done%0d", i), bus.st_done, 0);
      tick;
    end
    bus.mem2proc_response = 4'd0;
    #1;
    chk("st done", bus.st_done, 1);
    chk("st idle cmd", bus.proc2mem_command, 0);
    chk("st idle", bus.busy, 0);
    tick;
    #1;
    chk("st pulse", bus.st_done, 0);

    // Squash in IDLE with both requesters forces the store grant
    bus.ld_req_valid = 1'b1; bus.st_req_valid = 1'b1; squash = 1'b1;
    #1;
    chk("sq ld_ready", bus.ld_req_ready, 0);
    chk("sq st_ready", bus.st_req_ready, 1);
    clear_inputs();
    tick;

    // Squash while the load request is still being rejected drops it
    bus.ld_req_valid = 1'b1; bus.ld_req_addr = 32'h3000; bus.ld_req_funct3 = 3'b010; bus.ld_req_tag = 4'd3;
    tick;
    bus.ld_req_valid = 1'b0; squash = 1'b1;
    #1;
    chk("sqld cmd", bus.proc2mem_command, 1);
    tick;
    squash = 1'b0;
    #1;
    chk("sqld busy", bus.busy, 0);
    chk("sqld cmd2", bus.proc2mem_command, 0);
    tick;
    #1;
    chk("sqld no resp", bus.ld_resp_valid, 0);

    // Starvation: both requesters held continuously
    pat = "LLLLSLLLLS";
    bus.ld_req_valid = 1'b1; bus.ld_req_addr = 32'h40; bus.ld_req_funct3 = 3'b010; bus.ld_req_tag = 4'd1;
    bus.st_req_valid = 1'b1; bus.st_req_addr = 32'h80; bus.st_req_data = 32'h1; bus.st_req_size = 2'd2;
    #1;
    for (int i = 0; i < 10; i++) begin
      is_ld = (pat[i] == "L");
      chk($sformatf("grant%0d", i), {bus.ld_req_ready, bus.st_req_ready}, is_ld ? 2'b10 : 2'b01);
      tick;
      bus.mem2proc_response = is_ld ? 4'd2 : 4'd1;
      tick;
      bus.mem2proc_response = 4'd0;
      if (is_ld) begin
        bus.mem2proc_tag = 4'd2;
        tick;
        bus.mem2proc_tag = 4'd0;
      end
      #1;
    end
    clear_inputs();
    tick;

    // Squash during WAIT_DATA; tag arrives four cycles later
    bus.ld_req_valid = 1'b1; bus.ld_req_addr = 32'h3000; bus.ld_req_funct3 = 3'b010; bus.ld_req_tag = 4'd9;
    tick;
    bus.ld_req_valid = 1'b0; bus.mem2proc_response = 4'd4;
    tick;
    bus.mem2proc_response = 4'd0; squash = 1'b1;
    #1;
    chk("sqw busy", bus.busy, 1);
    chk("sqw ready", bus.ld_req_ready, 0);
    tick;
    squash = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("sqw hold%0d", i), bus.busy, 1);
      tick;
    end
    bus.mem2proc_tag = 4'd4; bus.mem2proc_data = 64'h5555_5555_5555_5555;
    #1;
    chk("sqw tag busy", bus.busy, 1);
    tick;
    bus.mem2proc_tag = 4'd0;
    #1;
    chk("sqw no resp", bus.ld_resp_valid, 0);
    chk("sqw idle", bus.busy, 0);
    do_load("post sq", 32'h1000, 3'b010, 4'd2, 64'h0000_0000_1234_5678, 32'h12345678);

    // Reset while a store is being retried
    bus.st_req_valid = 1'b1; bus.st_req_addr = 32'h2000; bus.st_req_data = 32'hCAFEF00D; bus.st_req_size = 2'd2;
    tick;
    bus.st_req_valid = 1'b0; rst = 1'b0;
    #1;
    chk("rstst cmd", bus.proc2mem_command, 2);
    chk("rstst ready", bus.st_req_ready, 0);
    tick;
    rst = 1'b1;
    #1;
    chk("rstst cmd after", bus.proc2mem_command, 0);
    chk("rstst done", bus.st_done, 0);
    chk("rstst busy", bus.busy, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
